// File: rtl/wildcube_pkg.sv
// Shared constants, state encoding and speed decode for the horizontal-line
// motion controller and its line counter.
package wildcube_pkg;

  localparam logic [15:0] START_Y = 16'd324;
  localparam logic [15:0] TOP_Y   = 16'd630;
  localparam logic [15:0] BOT_Y   = 16'd18;
  localparam int          BURST   = 2;
  localparam int          BURST_W = 8;
  localparam int          DIV_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN_UP = 2'd2,
    RUN_DW = 2'd3
  } state_t;

  // Frames per move event: spd 0..3 -> 8, 4, 2, 1.
  function automatic logic [3:0] k_of(input logic [1:0] spd);
    return 4'd8 >> spd;
  endfunction

endpackage

// File: rtl/hline_motion_ctrl_if.sv
// Link between the motion controller (master) and the line counter (slave):
// step enables, load strobe/value and the counter's limit flags.
interface hline_motion_ctrl_if;

  logic        UP;
  logic        DW;
  logic        LD;
  logic [15:0] D;
  logic        at_top;
  logic        at_bot;

  modport master (output UP, output DW, output LD, output D,
                  input at_top, input at_bot);
  modport slave  (input UP, input DW, input LD, input D,
                  output at_top, output at_bot);

endinterface

// File: rtl/frame_prescaler.sv
// Counts frame pulses and emits a one-cycle tick on every K-th counted frame,
// with K chosen by spd at the moment of comparison.
module frame_prescaler
  import wildcube_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame,
  input  logic [1:0] spd,
  input  logic       hold,
  input  logic       clr,
  output logic       tick
);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic [3:0]       k_m1;

  assign k_m1 = k_of(spd) - 4'd1;

  // A count already past a newly selected smaller K fires on the next frame.
  always_comb begin
    tick     = 1'b0;
    div_next = div_reg;
    if (clr) begin
      div_next = '0;
    end else if (frame && !hold) begin
      if ({1'b0, div_reg} >= k_m1) begin
        tick     = 1'b1;
        div_next = '0;
      end else begin
        div_next = div_reg + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_reg <= '0;
    else       div_reg <= div_next;
  end

endmodule

// File: rtl/hline_motion_ctrl.sv
// Moves a horizontal line up and down between the counter limits, issuing
// bursts of one-pixel steps at a frame-divided rate.
module hline_motion_ctrl #(
  parameter logic [15:0] START_Y = wildcube_pkg::START_Y,
  parameter int          BURST   = wildcube_pkg::BURST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame,
  input  logic                 start,
  input  logic                 freeze,
  input  logic [1:0]           spd,
  hline_motion_ctrl_if.master  lc,
  output logic                 dir,
  output logic                 moving
);

  import wildcube_pkg::*;

  state_t               state_reg;
  state_t               state_next;
  logic                 ld_reg;
  logic                 dir_reg;
  logic                 dir_next;
  logic [BURST_W-1:0]   burst_reg;
  logic [BURST_W-1:0]   burst_next;
  logic                 run;
  logic                 rev;
  logic                 step;
  logic                 tick;

  assign run  = (state_reg == RUN_UP) || (state_reg == RUN_DW);
  assign rev  = !start && !freeze &&
                (((state_reg == RUN_UP) && lc.at_top) ||
                 ((state_reg == RUN_DW) && lc.at_bot));
  assign step = lc.UP || lc.DW;

  // Start clears the divider, so a coincident frame pulse is discarded.
  frame_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .frame (frame),
    .spd   (spd),
    .hold  (freeze || !run),
    .clr   (start || (state_reg == LOAD)),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        IDLE:    state_next = IDLE;
        LOAD:    state_next = RUN_UP;
        RUN_UP:  if (rev) state_next = RUN_DW;
        RUN_DW:  if (rev) state_next = RUN_UP;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    lc.UP  = (state_reg == RUN_UP) && (burst_reg != '0) && !lc.at_top && !freeze;
    lc.DW  = (state_reg == RUN_DW) && (burst_reg != '0) && !lc.at_bot && !freeze;
    moving = run;
  end

  // A move event reloads the burst even if steps of the previous one remain.
  always_comb begin
    burst_next = burst_reg;
    dir_next   = dir_reg;
    if (start) begin
      burst_next = '0;
    end else if (state_reg == LOAD) begin
      burst_next = '0;
      dir_next   = 1'b1;
    end else if (rev) begin
      burst_next = '0;
      dir_next   = (state_reg == RUN_DW);
    end else if (tick) begin
      burst_next = BURST_W'(BURST);
    end else if (step) begin
      burst_next = burst_reg - BURST_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_reg    <= 1'b0;
      dir_reg   <= 1'b1;
      burst_reg <= '0;
    end else begin
      ld_reg    <= (state_next == LOAD);
      dir_reg   <= dir_next;
      burst_reg <= burst_next;
    end
  end

  assign lc.LD = ld_reg;
  assign lc.D  = START_Y;
  assign dir   = dir_reg;

endmodule
